// File: rtl/fp_add_pkg.sv
// Shared types and constants for the two-port floating-point adder arbiter.
package fp_add_pkg;

    localparam int OP_W = 32;
    localparam logic [OP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fp_add_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one external IEEE-754 single adder between two requesters, one operation at a time.
// state | meaning
// IDLE  | grant and accept one request ; ISSUE | pulse adder_en with captured operands
// WAIT  | wait for adder idle or timeout ; RESP | hold result for the captured requester
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int MIN_WAIT    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OP_W-1:0] req_a0,
    input  logic [OP_W-1:0] req_b0,
    input  logic [OP_W-1:0] req_a1,
    input  logic [OP_W-1:0] req_b1,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [OP_W-1:0] rsp_sum,
    output logic            rsp_err,
    output logic            adder_en,
    output logic [OP_W-1:0] adder_a,
    output logic [OP_W-1:0] adder_b,
    input  logic [OP_W-1:0] adder_sum,
    input  logic            adder_busy
);

    localparam int CNT_MAX = (TIMEOUT_CYC > MIN_WAIT) ? TIMEOUT_CYC : MIN_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT_CYC);

    state_e            state_q, state_d;
    logic              armed_q;
    logic              last_q;
    logic              id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              adder_en_q;
    logic [OP_W-1:0]   adder_a_q, adder_b_q;
    logic [OP_W-1:0]   rsp_sum_q;
    logic              rsp_err_q;
    logic [1:0]        rsp_valid_q;

    logic [1:0]        grant;
    logic              req_xfer, xfer_id, rsp_xfer, done, timeout;

    rr_arb2 u_rr (
        .valid (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    // armed_q keeps req_ready low until the first clock edge after reset release
    assign req_ready = (state_q == ST_IDLE && armed_q) ? grant : 2'b00;
    assign req_xfer  = |(req_valid & req_ready);
    assign xfer_id   = req_ready[1];
    assign rsp_xfer  = |(rsp_valid_q & rsp_ready);
    assign done      = (cnt_q >= MIN_W) && !adder_busy;
    assign timeout   = !done && (cnt_q >= TO_C);

    assign adder_en  = adder_en_q;
    assign adder_a   = adder_a_q;
    assign adder_b   = adder_b_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_valid = rsp_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_xfer) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done || timeout) state_d = ST_RESP;
            ST_RESP:  if (rsp_xfer) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            adder_en_q  <= 1'b0;
            adder_a_q   <= '0;
            adder_b_q   <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            adder_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_xfer) begin
                        id_q       <= xfer_id;
                        last_q     <= xfer_id;
                        adder_a_q  <= xfer_id ? req_a1 : req_a0;
                        adder_b_q  <= xfer_id ? req_b1 : req_b0;
                        adder_en_q <= 1'b1;
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    if (done) begin
                        rsp_sum_q   <= adder_sum;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= id_to_onehot(id_q);
                    end else if (timeout) begin
                        rsp_sum_q   <= QNAN;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= id_to_onehot(id_q);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: if (rsp_xfer) rsp_valid_q <= 2'b00;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: max cycles waited for adder completion.
REQ-002 SHALL have parameter MIN_WAIT, default 1: cycles after issue during which adder_busy is ignored.
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req_valid[1:0]  in  2  per-requester operand valid; req_ready[1:0]  out  2  per-requester accept.
REQ-005 SHALL have ports: req_a0, req_b0, req_a1, req_b1  in  32 each  IEEE-754 single operands per requester.
REQ-006 SHALL have ports: rsp_valid[1:0]  out  2  per-requester result valid; rsp_ready[1:0]  in  2  per-requester result accept.
REQ-007 SHALL have ports: rsp_sum  out  32  result; rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-008 SHALL have ports: adder_en  out  1  one-cycle start; adder_a, adder_b  out  32  operands; adder_sum  in  32  result; adder_busy  in  1  adder state non-idle.

Function
REQ-009 SHALL share one ieee_adder between two requesters, one operation outstanding at a time.
REQ-010 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-011 IDLE: req_ready asserted only for the granted requester, only when its req_valid is high; transfer on req_valid&req_ready captures operands and requester id; next state ISSUE.
REQ-012 Grant SHALL be round-robin: sole requester wins; on simultaneous requests the requester not granted last wins.
REQ-013 ISSUE: adder_en=1 for exactly one cycle, adder_a/adder_b = captured operands; next state WAIT.
REQ-014 adder_a/adder_b SHALL hold captured operands from ISSUE until leaving WAIT.
REQ-015 WAIT: first MIN_WAIT cycles ignore adder_busy; thereafter adder_busy==0 registers adder_sum into rsp_sum, rsp_err=0, next state RESP.
REQ-016 WAIT cycle counter SHALL start at 0 on ISSUE exit; at TIMEOUT_CYC with adder_busy still 1: rsp_sum=32'h7FC0_0000, rsp_err=1, next state RESP.
REQ-017 RESP: rsp_valid asserted only for the captured requester id; rsp_sum/rsp_err stable until rsp_ready; transfer -> IDLE.
REQ-018 Accept-to-adder_en latency SHALL be 1 cycle; adder completion (busy low sampled) to rsp_valid SHALL be 1 cycle.
REQ-019 No req_ready SHALL assert outside IDLE; new request accepted no earlier than the cycle after a response transfer.
REQ-020 rsp_ready on non-selected port SHALL be ignored; req_valid changes outside IDLE SHALL be ignored.
REQ-021 Round-robin pointer SHALL update only on request transfer.

Reset
REQ-022 rst SHALL asynchronously force: state IDLE, req_ready=0, rsp_valid=0, adder_en=0, adder_a/adder_b=0, rsp_sum=0, rsp_err=0, counter=0, last-grant=requester 1 (requester 0 first priority).
REQ-023 rst mid-operation SHALL abort the operation with no response; outputs reach reset values within the reset assertion.
REQ-024 First req_ready SHALL occur no earlier than the first clk edge after rst deassertion.

Structure
REQ-025 Package fp_add_pkg SHALL hold state enum, QNAN constant 32'h7FC0_0000, and operand width 32.
REQ-026 Round-robin grant logic SHALL be sub-module rr_arb2 (inputs valid[1:0], last; output grant one-hot).
REQ-027 ieee_adder SHALL be external; fp_add_arbiter SHALL contain no arithmetic.

Verification
REQ-028 Bench SHALL use a behavioural adder model with busy high 3 cycles after adder_en.
REQ-029 Single: port0 req 32'h4158_0000 + 32'h41BC_0000 -> adder_en 1 cycle after accept, rsp_valid[0] with rsp_sum 32'h4214_0000, rsp_err=0.
REQ-030 Simultaneous: both valid after reset -> port0 served first, then port1; repeat -> port0 served first again (round-robin alternation).
REQ-031 Backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1], rsp_sum stable, req_ready=0 throughout.
REQ-032 Timeout: model holds busy high forever -> after TIMEOUT_CYC, rsp_sum 32'h7FC0_0000, rsp_err=1.
REQ-033 Reset in WAIT: assert rst -> all outputs zero immediately; after release, port1 request served normally.
